// File: rtl/rv32_mod_alu_mc.sv
// rv32_mod_alu_mc: multi-cycle handshaked execute unit for the rv32 core.
//   Base RV32I ALU ops complete one cycle after accept. The optional M-extension
//   path is compiled in when RV32_ALU_MEXT_EN is defined. In that case MUL* ops
//   take one cycle, and DIV/REM run an iterative radix-2 divider with one
//   quotient bit per cycle. The result sits in a single-entry output register
//   that holds steady under backpressure.
// Ports:
//   clk, rstn (sync, active-low), kill (flush in-flight op and held result)
//   in_valid/in_ready, in_func[4:0] = {m_ext, alt, funct3}, in_a, in_b, in_tag
//   out_valid/out_ready, out_result, out_tag, out_illegal
//   busy: a division is iterating
module rv32_mod_alu_mc #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             kill,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_func,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             busy
);
  localparam int SH_W = $clog2(XLEN);

  typedef enum logic {IDLE, DIV} state_t;
  state_t state;

  logic [2:0]      f3;
  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] base_res;
  logic [XLEN-1:0] acc_res;
  logic            acc_ill;
  logic            accept;

  assign f3       = in_func[2:0];
  assign shamt    = in_b[SH_W-1:0];
  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !kill;
  assign accept   = in_valid && in_ready;

  always_comb begin
    base_res = in_a;
    case ({in_func[3], f3})
      4'b0000: base_res = in_a + in_b;
      4'b1000: base_res = in_a - in_b;
      4'b0001: base_res = in_a << shamt;
      4'b0010: base_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      4'b0011: base_res = {{(XLEN-1){1'b0}}, in_a < in_b};
      4'b0100: base_res = in_a ^ in_b;
      4'b0101: base_res = in_a >> shamt;
      4'b1101: base_res = $signed(in_a) >>> shamt;
      4'b0110: base_res = in_a | in_b;
      4'b0111: base_res = in_a & in_b;
      default: base_res = in_a;
    endcase
  end

`ifdef RV32_ALU_MEXT_EN
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  // Multiplier: sign- or zero-extend both operands to 2*XLEN. Then one
  // 2*XLEN-wide product serves every MUL variant.
  logic            mul_sa, mul_sb;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] mul_res;
  assign mul_sa  = in_a[XLEN-1] && (f3[1:0] != 2'b11);
  assign mul_sb  = in_b[XLEN-1] && !f3[1];
  assign prod    = {{XLEN{mul_sa}}, in_a} * {{XLEN{mul_sb}}, in_b};
  assign mul_res = (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Divider front end: signs, magnitudes and the two cases that bypass iteration
  logic            div_sgn, div_rem, sa, sb, b_zero, ovf;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;
  assign div_sgn  = !f3[0];
  assign div_rem  = f3[1];
  assign sa       = div_sgn && in_a[XLEN-1];
  assign sb       = div_sgn && in_b[XLEN-1];
  assign a_mag    = sa ? -in_a : in_a;
  assign b_mag    = sb ? -in_b : in_b;
  assign b_zero   = (in_b == '0);
  assign ovf      = div_sgn && (in_a == MIN_INT) && (in_b == '1);
  assign fast_res = b_zero ? (div_rem ? in_a : '1) : (div_rem ? '0 : MIN_INT);

  // Iteration state: dq shifts dividend bits out and quotient bits in
  logic [XLEN-1:0]  dq, dr, dd, q_nx, r_nx, div_final;
  logic [SH_W-1:0]  cnt;
  logic [TAG_W-1:0] d_tag;
  logic             neg_q, neg_r, d_rem, r_ge, acc_div;
  logic [XLEN:0]    r_sh, r_diff;

  assign r_sh      = {dr, dq[XLEN-1]};
  assign r_diff    = r_sh - {1'b0, dd};
  assign r_ge      = !r_diff[XLEN];
  assign r_nx      = r_ge ? r_diff[XLEN-1:0] : r_sh[XLEN-1:0];
  assign q_nx      = {dq[XLEN-2:0], r_ge};
  assign div_final = d_rem ? (neg_r ? -r_nx : r_nx) : (neg_q ? -q_nx : q_nx);

  always_comb begin
    acc_res = base_res;
    acc_ill = 1'b0;
    acc_div = 1'b0;
    if (in_func[4]) begin
      if (!f3[2])             acc_res = mul_res;
      else if (b_zero || ovf) acc_res = fast_res;
      else                    acc_div = 1'b1;
    end
  end
`else
  always_comb begin
    acc_res = base_res;
    acc_ill = 1'b0;
    if (in_func[4]) begin
      acc_res = '0;
      acc_ill = 1'b1;
    end
  end
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
`ifdef RV32_ALU_MEXT_EN
      busy        <= 1'b0;
`endif
    end else if (kill) begin
      state     <= IDLE;
      out_valid <= 1'b0;
`ifdef RV32_ALU_MEXT_EN
      busy      <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
`ifdef RV32_ALU_MEXT_EN
        if (acc_div) begin
          // The slot is free or being drained, so completion cannot clobber a result
          state <= DIV;
          busy  <= 1'b1;
          dq    <= a_mag;
          dr    <= '0;
          dd    <= b_mag;
          cnt   <= '0;
          neg_q <= sa ^ sb;
          neg_r <= sa;
          d_rem <= div_rem;
          d_tag <= in_tag;
        end else
`endif
        begin
          out_valid   <= 1'b1;
          out_result  <= acc_res;
          out_tag     <= in_tag;
          out_illegal <= acc_ill;
        end
      end
`ifdef RV32_ALU_MEXT_EN
      if (state == DIV) begin
        dq  <= q_nx;
        dr  <= r_nx;
        cnt <= cnt + 1'b1;
        if (cnt == SH_W'(XLEN-1)) begin
          state       <= IDLE;
          busy        <= 1'b0;
          out_valid   <= 1'b1;
          out_result  <= div_final;
          out_tag     <= d_tag;
          out_illegal <= 1'b0;
        end
      end
`endif
    end
  end
endmodule
